// File: rtl/consec_seq_checker.sv
// Multi-channel bring-up monitor for "rise(trig) |=> b[*MIN_REP:MAX_REP] ##1 c".
// Each channel flags pass/fail per attempt; fail counters saturate, err_sticky holds until clr_err.
module consec_seq_checker #(
  parameter int NCH     = 4,
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 2,
  parameter int CNT_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NCH-1:0]         abort,
  input  logic [NCH-1:0]         trig,
  input  logic [NCH-1:0]         b,
  input  logic [NCH-1:0]         c,
  input  logic                   clr_err,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         pass,
  output logic [NCH-1:0]         fail,
  output logic [NCH-1:0]         retrig,
  output logic [NCH*CNT_W-1:0]   fail_cnt,
  output logic                   err_sticky
);

  localparam int NW = $clog2(MAX_REP + 1);
  localparam logic [NW-1:0]    MIN_N   = NW'(MIN_REP);
  localparam logic [NW-1:0]    MAX_N   = NW'(MAX_REP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, REP} state_t;

  logic [NCH-1:0] trigQ;
  logic [NCH-1:0] failNext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) trigQ <= '0;
    else          trigQ <= trig;
  end

  for (genvar i = 0; i < NCH; i++) begin : gCh
    state_t           state, stateNext;
    logic [NW-1:0]    repCnt, repCntNext;
    logic             rise, passNext, chFail, retrigNext;
    logic             passQ, failQ, retrigQ;
    logic [CNT_W-1:0] cnt;

    assign rise = trig[i] & ~trigQ[i];

    // Abort has priority, then a legal c terminates, then b extends; anything else is a violation.
    // A rise seen while an attempt is open is never a new start, even on the deciding edge.
    always_comb begin
      stateNext  = state;
      repCntNext = repCnt;
      passNext   = 1'b0;
      chFail     = 1'b0;
      retrigNext = 1'b0;
      if (state == IDLE) begin
        if (rise && !abort[i]) begin
          stateNext  = REP;
          repCntNext = '0;
        end
      end else begin
        retrigNext = rise;
        if (abort[i]) begin
          stateNext = IDLE;
        end else if (repCnt >= MIN_N && c[i]) begin
          passNext  = 1'b1;
          stateNext = IDLE;
        end else if (b[i] && repCnt < MAX_N) begin
          repCntNext = repCnt + NW'(1);
        end else begin
          chFail    = 1'b1;
          stateNext = IDLE;
        end
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state   <= IDLE;
        repCnt  <= '0;
        passQ   <= 1'b0;
        failQ   <= 1'b0;
        retrigQ <= 1'b0;
      end else begin
        state   <= stateNext;
        repCnt  <= repCntNext;
        passQ   <= passNext;
        failQ   <= chFail;
        retrigQ <= retrigNext;
      end
    end

    // A fail on the clearing edge still counts, so the counter lands on 1 rather than 0.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (chFail) begin
        if (clr_err)             cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else if (clr_err) begin
        cnt <= '0;
      end
    end

    assign failNext[i]                 = chFail;
    assign busy[i]                     = (state == REP);
    assign pass[i]                     = passQ;
    assign fail[i]                     = failQ;
    assign retrig[i]                   = retrigQ;
    assign fail_cnt[i*CNT_W +: CNT_W]  = cnt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       err_sticky <= 1'b0;
    else if (|failNext) err_sticky <= 1'b1;
    else if (clr_err)   err_sticky <= 1'b0;
  end

endmodule
